// File: rtl/udp_loop_pkg.sv
`timescale 1ns/1ps
// Shared types and helpers for the UDP loopback controller.
package udp_loop_pkg;

  localparam int MAC_W  = 48;
  localparam int IP_W   = 32;
  localparam int PORT_W = 16;
  localparam int LEN_W  = 16;

  // One-hot controller states.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'b001,
    ST_LAUNCH = 3'b010,
    ST_SEND   = 3'b100
  } state_t;

  // Increment a 16-bit event counter when en is set, sticking at all-ones.
  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
    if (en && (v != 16'hFFFF)) begin
      return v + 16'd1;
    end
    return v;
  endfunction

endpackage

// File: rtl/loop_buf_ram.sv
`timescale 1ns/1ps
// Simple dual-port byte RAM: one write port, one registered read port.
// Contents are not reset so the array maps onto block RAM.
module loop_buf_ram #(
  parameter int ADDR_W = 11
) (
  input  logic              clk_125m,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [7:0]        rdata
);

  logic [7:0] mem [0:(1<<ADDR_W)-1];

  // Synchronous write and registered read; rdata holds when re is low.
  always_ff @(posedge clk_125m) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/udp_loopback_ctrl.sv
`timescale 1ns/1ps
// Buffers one received UDP payload and sequences its return transmission
// to the sender; bad, oversize or busy-time packets are dropped and counted.
//
// TX byte handshake: tx_data_req is a request with no back-pressure; a
// request seen in SEND during cycle n presents the byte on tx_data in cycle
// n+1. Without a request tx_data holds its last value. Requests past
// tx_data_len return 8'h00 and do not advance the read pointer.
module udp_loopback_ctrl
  import udp_loop_pkg::*;
#(
  parameter int          ADDR_W     = 11,
  parameter logic [15:0] TX_TIMEOUT = 16'd20000
) (
  input  logic              clk_125m,
  input  logic              rst_n,
  input  logic              rx_payload_valid,
  input  logic [7:0]        rx_payload_data,
  input  logic              rx_pkt_done,
  input  logic              rx_pkt_err,
  input  logic [LEN_W-1:0]  rx_data_len,
  input  logic [MAC_W-1:0]  rx_exter_mac,
  input  logic [IP_W-1:0]   rx_exter_ip,
  input  logic [PORT_W-1:0] rx_exter_port,
  output logic              data_overflow_o,
  output logic              tx_start,
  output logic [MAC_W-1:0]  tx_dst_mac,
  output logic [IP_W-1:0]   tx_dst_ip,
  output logic [PORT_W-1:0] tx_dst_port,
  output logic [LEN_W-1:0]  tx_data_len,
  input  logic              tx_data_req,
  output logic [7:0]        tx_data,
  input  logic              tx_done,
  output logic              busy,
  output logic [15:0]       pkt_loop_cnt,
  output logic [15:0]       pkt_drop_cnt,
  output state_t            dbg_state
);

  localparam logic [16:0]     DEPTH_CNT = 17'(1 << ADDR_W);
  localparam logic [ADDR_W-1:0] WR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   RD_ONE  = (ADDR_W+1)'(1);

  state_t            state;

  // RX capture state
  logic              rx_active;
  logic              accept;
  logic              ovf;
  logic [ADDR_W-1:0] wr_ptr;
  logic [16:0]       wr_cnt;

  logic              first_byte;
  logic              accept_now;
  logic [16:0]       cnt_before;
  logic              ovf_before;
  logic              byte_ovf;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic              rx_active_n;
  logic              accept_n;
  logic              ovf_n;
  logic [ADDR_W-1:0] wr_ptr_n;
  logic [16:0]       wr_cnt_n;
  logic              commit_good;
  logic              commit_drop;

  // TX read state
  logic [ADDR_W:0]   rd_ptr;
  logic [15:0]       tmo_cnt;
  logic              data_vld_q;
  logic              rd_req;
  logic              in_range;
  logic              ram_re;
  logic [7:0]        ram_rdata;
  logic              tx_loop;
  logic              tx_tmo;

  loop_buf_ram #(.ADDR_W(ADDR_W)) u_buf (
    .clk_125m (clk_125m),
    .we       (ram_we),
    .waddr    (ram_waddr),
    .wdata    (rx_payload_data),
    .re       (ram_re),
    .raddr    (rd_ptr[ADDR_W-1:0]),
    .rdata    (ram_rdata)
  );

  // Next-state of the RX capture path and the commit decision.
  always_comb begin
    first_byte  = rx_payload_valid & ~rx_active;
    accept_now  = first_byte ? (state == ST_IDLE) : accept;
    cnt_before  = first_byte ? 17'd0 : wr_cnt;
    ovf_before  = first_byte ? 1'b0 : ovf;
    byte_ovf    = rx_payload_valid & accept_now & (cnt_before >= DEPTH_CNT);
    ram_we      = rx_payload_valid & ~rx_pkt_done & accept_now & ~byte_ovf;
    ram_waddr   = first_byte ? '0 : wr_ptr;

    rx_active_n = rx_active;
    accept_n    = accept;
    ovf_n       = ovf;
    wr_ptr_n    = wr_ptr;
    wr_cnt_n    = wr_cnt;
    if (rx_pkt_done) begin
      rx_active_n = 1'b0;
      ovf_n       = 1'b0;
    end else if (rx_payload_valid) begin
      rx_active_n = 1'b1;
      accept_n    = accept_now;
      ovf_n       = ovf_before | byte_ovf;
      wr_cnt_n    = (&cnt_before) ? cnt_before : cnt_before + 17'd1;
      wr_ptr_n    = ram_we ? ram_waddr + WR_ONE : ram_waddr;
    end

    commit_good = rx_pkt_done & rx_active & accept & ~ovf & ~rx_pkt_err &
                  (rx_data_len != 16'd0) & (wr_cnt == {1'b0, rx_data_len});
    commit_drop = rx_pkt_done & ~commit_good;
  end

  // RX capture registers; the overflow flag is taken from next-state values
  // so it rises with the offending byte and falls right after rx_pkt_done.
  always_ff @(posedge clk_125m or negedge rst_n) begin
    if (!rst_n) begin
      rx_active       <= 1'b0;
      accept          <= 1'b0;
      ovf             <= 1'b0;
      wr_ptr          <= '0;
      wr_cnt          <= '0;
      data_overflow_o <= 1'b0;
    end else begin
      rx_active       <= rx_active_n;
      accept          <= accept_n;
      ovf             <= ovf_n;
      wr_ptr          <= wr_ptr_n;
      wr_cnt          <= wr_cnt_n;
      data_overflow_o <= rx_active_n & (ovf_n | ~accept_n);
    end
  end

  // TX-side request decode and completion events.
  always_comb begin
    rd_req   = (state == ST_SEND) & tx_data_req;
    in_range = (16'(rd_ptr) < tx_data_len);
    ram_re   = rd_req & in_range;
    tx_loop  = (state == ST_SEND) & tx_done;
    tx_tmo   = (state == ST_SEND) & ~tx_done & (tmo_cnt == TX_TIMEOUT - 16'd1);
  end

  // Controller FSM with its registered TX outputs and event counters.
  always_ff @(posedge clk_125m or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      tx_start     <= 1'b0;
      tx_dst_mac   <= '0;
      tx_dst_ip    <= '0;
      tx_dst_port  <= '0;
      tx_data_len  <= '0;
      rd_ptr       <= '0;
      tmo_cnt      <= '0;
      data_vld_q   <= 1'b0;
      pkt_loop_cnt <= '0;
      pkt_drop_cnt <= '0;
    end else begin
      tx_start <= 1'b0;
      if (commit_good) begin
        tx_dst_mac  <= rx_exter_mac;
        tx_dst_ip   <= rx_exter_ip;
        tx_dst_port <= rx_exter_port;
        tx_data_len <= rx_data_len;
      end
      case (state)
        ST_IDLE: begin
          if (commit_good) begin
            state    <= ST_LAUNCH;
            tx_start <= 1'b1;
          end
        end
        ST_LAUNCH: begin
          rd_ptr  <= '0;
          tmo_cnt <= '0;
          state   <= ST_SEND;
        end
        ST_SEND: begin
          tmo_cnt <= tmo_cnt + 16'd1;
          if (rd_req) begin
            data_vld_q <= in_range;
            if (in_range) begin
              rd_ptr <= rd_ptr + RD_ONE;
            end
          end
          if (tx_loop || tx_tmo) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
      pkt_loop_cnt <= sat_inc(pkt_loop_cnt, tx_loop);
      pkt_drop_cnt <= sat_inc(sat_inc(pkt_drop_cnt, commit_drop), tx_tmo);
    end
  end

  assign tx_data   = data_vld_q ? ram_rdata : 8'h00;
  assign busy      = (state != ST_IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_udp_loopback_ctrl.sv
`timescale 1ns/1ps
// Directed bench for udp_loopback_ctrl: good loop, error/short/empty drops,
// oversize, busy-time packet, TX timeout and asynchronous reset mid-SEND.
module tb_udp_loopback_ctrl;
  import udp_loop_pkg::*;

  localparam int          ADDR_W     = 11;
  localparam logic [15:0] TX_TIMEOUT = 16'd100;

  localparam logic [47:0] MAC_A  = 48'h000a35010203;
  localparam logic [31:0] IP_A   = 32'hc0a80003;
  localparam logic [15:0] PORT_A = 16'd5000;
  localparam logic [47:0] MAC_B  = 48'h000a35aabbcc;
  localparam logic [31:0] IP_B   = 32'hc0a80007;
  localparam logic [15:0] PORT_B = 16'd6000;

  logic        clk_125m;
  logic        rst_n;
  logic        rx_payload_valid;
  logic [7:0]  rx_payload_data;
  logic        rx_pkt_done;
  logic        rx_pkt_err;
  logic [15:0] rx_data_len;
  logic [47:0] rx_exter_mac;
  logic [31:0] rx_exter_ip;
  logic [15:0] rx_exter_port;
  logic        data_overflow_o;
  logic        tx_start;
  logic [47:0] tx_dst_mac;
  logic [31:0] tx_dst_ip;
  logic [15:0] tx_dst_port;
  logic [15:0] tx_data_len;
  logic        tx_data_req;
  logic [7:0]  tx_data;
  logic        tx_done;
  logic        busy;
  logic [15:0] pkt_loop_cnt;
  logic [15:0] pkt_drop_cnt;
  state_t      dbg_state;

  udp_loopback_ctrl #(.ADDR_W(ADDR_W), .TX_TIMEOUT(TX_TIMEOUT)) dut (
    .clk_125m         (clk_125m),
    .rst_n            (rst_n),
    .rx_payload_valid (rx_payload_valid),
    .rx_payload_data  (rx_payload_data),
    .rx_pkt_done      (rx_pkt_done),
    .rx_pkt_err       (rx_pkt_err),
    .rx_data_len      (rx_data_len),
    .rx_exter_mac     (rx_exter_mac),
    .rx_exter_ip      (rx_exter_ip),
    .rx_exter_port    (rx_exter_port),
    .data_overflow_o  (data_overflow_o),
    .tx_start         (tx_start),
    .tx_dst_mac       (tx_dst_mac),
    .tx_dst_ip        (tx_dst_ip),
    .tx_dst_port      (tx_dst_port),
    .tx_data_len      (tx_data_len),
    .tx_data_req      (tx_data_req),
    .tx_data          (tx_data),
    .tx_done          (tx_done),
    .busy             (busy),
    .pkt_loop_cnt     (pkt_loop_cnt),
    .pkt_drop_cnt     (pkt_drop_cnt),
    .dbg_state        (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk_125m = 1'b0;
  always #4 clk_125m = ~clk_125m;

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk_125m);
    #1;
  endtask

  task automatic send_bytes(input int n, input logic [15:0] len, input logic [7:0] base,
                            input bit expect_loop);
    rx_data_len = len;
    for (int i = 0; i < n; i++) begin
      rx_payload_valid = 1'b1;
      rx_payload_data  = 8'(base + i);
      if (expect_loop) exp_q.push_back(8'(base + i));
      tick();
    end
    rx_payload_valid = 1'b0;
    rx_payload_data  = 8'h00;
  endtask

  task automatic done_pulse(input logic err, input logic [47:0] mac, input logic [31:0] ip,
                            input logic [15:0] port);
    rx_exter_mac  = mac;
    rx_exter_ip   = ip;
    rx_exter_port = port;
    rx_pkt_err    = err;
    rx_pkt_done   = 1'b1;
    tick();
    rx_pkt_done   = 1'b0;
    rx_pkt_err    = 1'b0;
  endtask

  task automatic read_bytes(input int n, input string tag);
    logic [7:0] exp_b;
    for (int i = 0; i < n; i++) begin
      tx_data_req = 1'b1;
      tick();
      exp_b = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
      check(tag, tx_data, exp_b);
    end
    tx_data_req = 1'b0;
  endtask

  task automatic finish_tx();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    rst_n            = 1'b0;
    rx_payload_valid = 1'b0;
    rx_payload_data  = 8'h00;
    rx_pkt_done      = 1'b0;
    rx_pkt_err       = 1'b0;
    rx_data_len      = 16'd0;
    rx_exter_mac     = '0;
    rx_exter_ip      = '0;
    rx_exter_port    = '0;
    tx_data_req      = 1'b0;
    tx_done          = 1'b0;
    repeat (3) tick();

    // reset state
    check("rst_tx_start", tx_start, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_state", dbg_state, ST_IDLE);
    check("rst_ovf", data_overflow_o, 1'b0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_dst_mac", tx_dst_mac, 48'h0);
    check("rst_loop", pkt_loop_cnt, 16'd0);
    check("rst_drop", pkt_drop_cnt, 16'd0);
    rst_n = 1'b1;
    tick();

    // 1: 18-byte good packet loops back
    send_bytes(18, 16'd18, 8'h00, 1'b1);
    check("t1_ovf_rx", data_overflow_o, 1'b0);
    done_pulse(1'b0, MAC_A, IP_A, PORT_A);
    check("t1_start", tx_start, 1'b1);
    check("t1_state_launch", dbg_state, ST_LAUNCH);
    check("t1_mac", tx_dst_mac, MAC_A);
    check("t1_ip", tx_dst_ip, IP_A);
    check("t1_port", tx_dst_port, PORT_A);
    check("t1_len", tx_data_len, 16'd18);
    tick();
    check("t1_start_pulse", tx_start, 1'b0);
    check("t1_state_send", dbg_state, ST_SEND);
    read_bytes(18, "t1_data");
    tick();
    check("t1_hold", tx_data, 8'h11);
    tx_data_req = 1'b1;
    tick();
    tx_data_req = 1'b0;
    check("t1_past_len", tx_data, 8'h00);
    finish_tx();
    check("t1_busy", busy, 1'b0);
    check("t1_loop", pkt_loop_cnt, 16'd1);
    check("t1_drop", pkt_drop_cnt, 16'd0);

    // 2: error packet, empty done, short packet -> drops
    send_bytes(18, 16'd18, 8'h00, 1'b0);
    done_pulse(1'b1, MAC_A, IP_A, PORT_A);
    check("t2_no_start", tx_start, 1'b0);
    check("t2_idle", dbg_state, ST_IDLE);
    check("t2_drop", pkt_drop_cnt, 16'd1);
    rx_data_len = 16'd0;
    done_pulse(1'b0, MAC_B, IP_B, PORT_B);
    check("t2_empty_drop", pkt_drop_cnt, 16'd2);
    send_bytes(5, 16'd6, 8'h30, 1'b0);
    done_pulse(1'b0, MAC_B, IP_B, PORT_B);
    check("t2_short_drop", pkt_drop_cnt, 16'd3);
    check("t2_short_busy", busy, 1'b0);
    check("t2_dst_hold", tx_dst_port, PORT_A);

    // 3: 2049-byte packet overflows the buffer
    rx_data_len = 16'd2049;
    for (int i = 1; i <= 2049; i++) begin
      rx_payload_valid = 1'b1;
      rx_payload_data  = 8'(i);
      tick();
      if (i == 2048) check("t3_ovf_2048", data_overflow_o, 1'b0);
      if (i == 2049) check("t3_ovf_2049", data_overflow_o, 1'b1);
    end
    rx_payload_valid = 1'b0;
    rx_exter_mac = MAC_B;
    rx_pkt_done  = 1'b1;
    #2;
    check("t3_ovf_at_done", data_overflow_o, 1'b1);
    tick();
    rx_pkt_done = 1'b0;
    check("t3_ovf_after", data_overflow_o, 1'b0);
    check("t3_no_start", tx_start, 1'b0);
    check("t3_drop", pkt_drop_cnt, 16'd4);

    // 4: second packet arrives while the first is being sent
    send_bytes(18, 16'd18, 8'h40, 1'b1);
    done_pulse(1'b0, MAC_B, IP_B, PORT_B);
    check("t4_start", tx_start, 1'b1);
    tick();
    rx_data_len = 16'd10;
    for (int i = 0; i < 10; i++) begin
      rx_payload_valid = 1'b1;
      rx_payload_data  = 8'(8'hA0 + i);
      tick();
      if (i == 0) check("t4_ovf_first", data_overflow_o, 1'b1);
      if (i == 9) check("t4_ovf_last", data_overflow_o, 1'b1);
    end
    rx_payload_valid = 1'b0;
    done_pulse(1'b0, MAC_A, IP_A, PORT_A);
    check("t4_ovf_after", data_overflow_o, 1'b0);
    check("t4_drop", pkt_drop_cnt, 16'd5);
    check("t4_still_send", dbg_state, ST_SEND);
    check("t4_dst_port", tx_dst_port, PORT_B);
    check("t4_len_hold", tx_data_len, 16'd18);
    read_bytes(18, "t4_data");
    finish_tx();
    check("t4_loop", pkt_loop_cnt, 16'd2);

    // 5: no tx_done -> timeout, then a normal packet
    send_bytes(8, 16'd8, 8'h60, 1'b1);
    done_pulse(1'b0, MAC_A, IP_A, PORT_A);
    tick();
    n = 0;
    while (busy && n < 4 * int'(TX_TIMEOUT)) begin
      tick();
      n++;
    end
    check("t5_tmo_cycles", 64'(n), 64'(TX_TIMEOUT));
    check("t5_idle", dbg_state, ST_IDLE);
    check("t5_drop", pkt_drop_cnt, 16'd6);
    check("t5_loop", pkt_loop_cnt, 16'd2);
    exp_q.delete();
    send_bytes(4, 16'd4, 8'h77, 1'b1);
    done_pulse(1'b0, MAC_B, IP_B, PORT_B);
    check("t5_restart", tx_start, 1'b1);
    check("t5_ip", tx_dst_ip, IP_B);
    tick();
    read_bytes(4, "t5_data");
    finish_tx();
    check("t5_loop_after", pkt_loop_cnt, 16'd3);

    // 6: asynchronous reset mid-SEND
    send_bytes(6, 16'd6, 8'h90, 1'b1);
    done_pulse(1'b0, MAC_A, IP_A, PORT_A);
    tick();
    read_bytes(2, "t6_pre");
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_busy", busy, 1'b0);
    check("t6_rst_state", dbg_state, ST_IDLE);
    check("t6_rst_tx_data", tx_data, 8'h00);
    check("t6_rst_mac", tx_dst_mac, 48'h0);
    check("t6_rst_len", tx_data_len, 16'd0);
    check("t6_rst_loop", pkt_loop_cnt, 16'd0);
    check("t6_rst_drop", pkt_drop_cnt, 16'd0);
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    tick();
    send_bytes(6, 16'd6, 8'h20, 1'b1);
    done_pulse(1'b0, MAC_B, IP_B, PORT_B);
    check("t6_start", tx_start, 1'b1);
    check("t6_mac", tx_dst_mac, MAC_B);
    tick();
    read_bytes(6, "t6_data");
    finish_tx();
    check("t6_loop", pkt_loop_cnt, 16'd1);
    check("t6_drop", pkt_drop_cnt, 16'd0);
    check("t6_busy", busy, 1'b0);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/udp_loopback_ctrl.md
Name: udp_loopback_ctrl

Overview:
Controller between the UDP/GMII receive datapath and the UDP transmit engine in the loopback design. It buffers one received payload in an internal byte RAM. A good packet is committed and the return transmission is sequenced to the sender's MAC/IP/port. Bad, oversize or busy-time packets are dropped and counted, and the transmitter is guarded with a timeout.

Parameters:
ADDR_W, 11, byte-buffer address width; depth = 2**ADDR_W bytes (2048).
TX_TIMEOUT, 16'd20000, clk_125m cycles allowed from tx_start to tx_done before abort.

Ports:
clk_125m  in  1  sole clock (GMII RX clock domain, 125 MHz)
rst_n  in  1  asynchronous active-low reset
rx_payload_valid  in  1  payload byte strobe from RX parser
rx_payload_data  in  8  payload byte
rx_pkt_done  in  1  one-cycle end-of-packet pulse
rx_pkt_err  in  1  CRC/overflow error, valid with rx_pkt_done
rx_data_len  in  16  UDP payload length, stable before first payload byte
rx_exter_mac  in  48  sender MAC, valid with rx_pkt_done
rx_exter_ip  in  32  sender IP, valid with rx_pkt_done
rx_exter_port  in  16  sender UDP port, valid with rx_pkt_done
data_overflow_o  out  1  buffer overflow/busy indication to RX parser
tx_start  out  1  one-cycle transmit launch pulse
tx_dst_mac  out  48  destination MAC for TX
tx_dst_ip  out  32  destination IP for TX
tx_dst_port  out  16  destination UDP port for TX
tx_data_len  out  16  payload length for TX
tx_data_req  in  1  TX engine byte request
tx_data  out  8  payload byte, 1 cycle after tx_data_req
tx_done  in  1  TX engine completion pulse
busy  out  1  high whenever FSM is not IDLE
pkt_loop_cnt  out  16  packets looped back, saturating
pkt_drop_cnt  out  16  packets dropped, saturating

Behaviour:
- Clock, reset: one clock clk_125m; reset is asynchronous, active-low (rst_n). All registers and outputs reset to 0, and the FSM resets to IDLE. RAM contents are not reset. Reset mid-packet or mid-TX abandons the packet silently with no counter update.
- RX capture:
  - The first rx_payload_valid after idle sets rx_active and latches accept = (state==IDLE).
  - wr_ptr is zeroed on that first byte, so byte k of the packet is written at address k.
  - When accept=1, each valid byte is written to mem[wr_ptr] and wr_ptr increments.
  - wr_cnt (17 bit) counts every valid byte regardless of accept.
- Overflow: if accept=1 and wr_cnt reaches 2**ADDR_W, further bytes are not written and ovf is set.
- data_overflow_o = rx_active & (ovf | ~accept). It is registered, deasserting the cycle after rx_pkt_done.
- Commit on rx_pkt_done (rx_active and ovf cleared the same cycle). A packet is good iff all hold:
  - accept=1
  - ovf=0
  - rx_pkt_err=0
  - rx_data_len != 0
  - wr_cnt == rx_data_len
- Good packet: latch rx_exter_* into tx_dst_*, latch rx_data_len into tx_data_len, and move to LAUNCH.
- Not-good packet: pkt_drop_cnt++.
- rx_pkt_done with no preceding payload byte counts as a drop.
- FSM IDLE:
  - Good commit -> LAUNCH.
- FSM LAUNCH:
  - tx_start=1 for exactly this one cycle, the cycle after rx_pkt_done.
  - rd_ptr=0 and tmo_cnt=0.
  - -> SEND.
- FSM SEND:
  - Each tx_data_req cycle: tx_data <= mem[rd_ptr], rd_ptr++.
  - Requests beyond tx_data_len return 8'h00, and rd_ptr holds.
  - tmo_cnt increments every cycle.
  - tx_done -> IDLE and pkt_loop_cnt++.
  - tmo_cnt == TX_TIMEOUT-1 without tx_done -> IDLE and pkt_drop_cnt++.
  - tx_done in the same cycle as timeout counts as a loop, not a drop.
- tx_done outside SEND is ignored.
- tx_data holds its last value when there is no request.
- tx_dst_* and tx_data_len hold until the next commit.
- A packet whose first byte arrives in LAUNCH/SEND has accept=0 and is dropped at its rx_pkt_done. The buffer is never written while TX reads it.
- Counters saturate at 16'hFFFF.
- Both counters incremented in one cycle: drop and loop are separate registers, so both update.

Decomposition:
- Shared package udp_loop_pkg holds:
  - FSM state encodings (one-hot, 3 bits: IDLE, LAUNCH, SEND)
  - the saturating-increment function
  - the MAC/IP/port width constants (48/32/16)
- One sub-module is natural: loop_buf_ram, a simple dual-port byte RAM with registered read and ADDR_W parameter, inferring block RAM.

Test Plan:
- 18-byte good packet (len=18, err=0, bytes 0x00..0x11, sender 00:0a:35:01:02:03/192.168.0.3:5000) -> tx_start 1 cycle after done; tx_dst_* match the sender; tx_data_len=18; 18 reqs return 0x00..0x11 each 1 cycle later; tx_done -> pkt_loop_cnt=1, busy=0.
- Same packet with rx_pkt_err=1 at done -> no tx_start, pkt_drop_cnt=1, FSM stays IDLE.
- 2049-byte packet (len=2049) -> data_overflow_o high from the byte-2049 write attempt until the cycle after done; drop=1; no tx_start.
- Second packet starts while in SEND -> data_overflow_o high throughout it; drop=1. First packet's tx_data is uncorrupted; loop=1 after tx_done.
- tx_done never asserted -> after TX_TIMEOUT cycles FSM returns to IDLE with drop=1. A subsequent good packet launches normally.
- rst_n pulsed low mid-SEND -> all outputs 0 immediately (async), counters 0, FSM IDLE; a following good packet loops correctly.
